// File: rtl/mux_pkg.sv
// Shared helpers and constants for the cascaded mux pipeline.
package mux_pkg;

    localparam int ERR_CNT_W = 8;

    // Index width for an N-way select, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_range.sv
// Combinational N-to-1 word select with an out-of-range flag.
module mux_nto1_range
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N*WIDTH-1:0] vec_in,
    input  logic [IDX_W-1:0]   idx,
    output logic [WIDTH-1:0]   word_out,
    output logic               oor
);

    // Decode the index; any unmatched index reads as zero and raises oor.
    always_comb begin
        word_out = '0;
        oor      = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                word_out = vec_in[i*WIDTH +: WIDTH];
                oor      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_cascade_pipe.sv
// Two-stage pipelined cascaded mux: sel picks a code, the code picks a data word.
// Valid/ready handshake with full back-pressure and a saturating error count.
module mux_cascade_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_DATA = 4,
    parameter int N_CTRL = 2,
    parameter int DSEL_W = $clog2(N_DATA),
    parameter int CSEL_W = $clog2(N_CTRL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CSEL_W-1:0]         sel,
    input  logic [N_CTRL*DSEL_W-1:0]  ctrl_codes,
    input  logic [N_DATA*WIDTH-1:0]   data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          y,
    output logic                      y_err,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    logic                     s2_en;
    logic                     s1_en;

    logic                     s1_v_q,      s1_v_d;
    logic [DSEL_W-1:0]        s1_code_q,   s1_code_d;
    logic                     s1_selerr_q, s1_selerr_d;
    logic [N_DATA*WIDTH-1:0]  s1_data_q,   s1_data_d;

    logic                     out_valid_q, out_valid_d;
    logic [WIDTH-1:0]         y_q,         y_d;
    logic                     y_err_q,     y_err_d;
    logic [ERR_CNT_W-1:0]     err_cnt_q,   err_cnt_d;

    logic [DSEL_W-1:0]        code_word;
    logic                     code_oor;
    logic [WIDTH-1:0]         data_word;
    logic                     data_oor;

    mux_nto1_range #(
        .WIDTH (DSEL_W),
        .N     (N_CTRL)
    ) u_code_mux (
        .vec_in   (ctrl_codes),
        .idx      (sel),
        .word_out (code_word),
        .oor      (code_oor)
    );

    mux_nto1_range #(
        .WIDTH (WIDTH),
        .N     (N_DATA)
    ) u_data_mux (
        .vec_in   (s1_data_q),
        .idx      (s1_code_q),
        .word_out (data_word),
        .oor      (data_oor)
    );

    // Advance enables depend only on registered state, never on in_valid.
    always_comb begin
        s2_en = !out_valid_q || out_ready;
        s1_en = !s1_v_q || s2_en;
    end

    // Next-state for both stage banks and the error counter.
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_code_d   = s1_code_q;
        s1_selerr_d = s1_selerr_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_err_d     = y_err_q;
        err_cnt_d   = err_cnt_q;

        if (s1_en) begin
            s1_v_d      = in_valid;
            s1_code_d   = code_word;
            s1_selerr_d = code_oor;
            s1_data_d   = data_in;
        end

        if (s2_en) begin
            out_valid_d = s1_v_q;
            y_d         = s1_selerr_q ? '0 : data_word;
            y_err_d     = s1_selerr_q || data_oor;
        end

        if (out_valid_q && out_ready && y_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_code_q   <= '0;
            s1_selerr_q <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_err_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_code_q   <= s1_code_d;
            s1_selerr_q <= s1_selerr_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_err_q     <= y_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = s1_en;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_err     = y_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_cascade_pipe.sv
// Self-checking bench for mux_cascade_pipe (WIDTH=8, N_DATA=3, N_CTRL=3).
module tb_mux_cascade_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [5:0]  ctrl_codes;
    logic [23:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        y_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int err_model = 0;

    logic [8:0] exp_q[$];
    logic       last_stall = 1'b0;
    logic [8:0] last_out = '0;

    typedef struct {
        logic [1:0]  sel;
        logic [5:0]  codes;
        logic [23:0] data;
        logic [7:0]  exp_y;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    mux_cascade_pipe #(
        .WIDTH  (8),
        .N_DATA (3),
        .N_CTRL (3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .ctrl_codes (ctrl_codes),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_err      (y_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: {err, y} for one beat.
    function automatic logic [8:0] ref_mux(input logic [1:0] s, input logic [5:0] c, input logic [23:0] d);
        logic [1:0] code;
        if (s >= 2'd3) return 9'h100;
        code = c[s*2 +: 2];
        if (code >= 2'd3) return 9'h100;
        return {1'b0, d[code*8 +: 8]};
    endfunction

    // Drive one beat from a negedge and hold it until accepted.
    task automatic drive_beat(input logic [1:0] s, input logic [5:0] c, input logic [23:0] d,
                              input logic [8:0] e, output int waits);
        waits = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        sel        = s;
        ctrl_codes = c;
        data_in    = d;
        forever begin
            #4;
            if (in_ready) begin
                exp_q.push_back(e);
                acc_cnt++;
                break;
            end
            if (waits >= 50) begin
                check("accept_timeout", waits, 0);
                break;
            end
            waits++;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #4;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            exp_q.delete();
            err_model  = 0;
            last_stall = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", {y_err, y});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out", {y_err, y}, e);
                    if (e[8] && err_model != 255) err_model++;
                end
            end
            if (out_valid && !out_ready) begin
                if (last_stall) check("stall_hold", {y_err, y}, last_out);
                last_stall = 1'b1;
                last_out   = {y_err, y};
            end else begin
                last_stall = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic [5:0]  rc;
        logic [23:0] rd;

        vecs[0] = '{2'd1, 6'b00_10_01, 24'h33_22_11, 8'h33, 1'b0};
        vecs[1] = '{2'd0, 6'b00_10_01, 24'h33_22_11, 8'h22, 1'b0};
        vecs[2] = '{2'd2, 6'b00_10_01, 24'h33_22_11, 8'h11, 1'b0};
        vecs[3] = '{2'd3, 6'b00_10_01, 24'h33_22_11, 8'h00, 1'b1};
        vecs[4] = '{2'd0, 6'b00_00_11, 24'h33_22_11, 8'h00, 1'b1};
        vecs[5] = '{2'd2, 6'b11_00_00, 24'hA5_5A_C3, 8'h00, 1'b1};
        vecs[6] = '{2'd1, 6'b00_00_00, 24'hA5_5A_C3, 8'hC3, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; ctrl_codes = '0; data_in = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_err_cnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Single beat and its latency.
        drive_beat(2'd1, 6'b00_10_01, 24'h33_22_11, 9'h033, w);
        idle();
        #4;
        check("lat_early", out_valid, 0);
        @(negedge clk);
        #4;
        check("lat_valid", out_valid, 1);
        check("single_y", y, 8'h33);
        wait_drain();
        check("err_cnt_zero", err_cnt, 0);

        // Single code-range error: err_cnt 0 -> 1.
        drive_beat(2'd0, 6'b00_00_11, 24'h33_22_11, 9'h100, w);
        idle();
        wait_drain();
        check("err_cnt_one", err_cnt, 1);

        // Table vectors.
        for (int i = 0; i < 7; i++) begin
            drive_beat(vecs[i].sel, vecs[i].codes, vecs[i].data, {vecs[i].exp_err, vecs[i].exp_y}, w);
        end
        idle();
        wait_drain();
        check("err_cnt_table", err_cnt, 4);

        // Streaming at full rate.
        for (int i = 0; i < 16; i++) begin
            rc = 6'($urandom_range(0, 63));
            rd = 24'($urandom);
            drive_beat(2'(i % 2), rc, rd, ref_mux(2'(i % 2), rc, rd), w);
            check("stream_rdy", w, 0);
        end
        idle();
        wait_drain();
        check("err_cnt_stream", err_cnt, err_model);

        // Back-pressure: only two beats fit while the output is stalled.
        acc_cnt = 0;
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    drive_beat(2'(i % 3), 6'b00_10_01, 24'h77_66_55 + 24'(i),
                               ref_mux(2'(i % 3), 6'b00_10_01, 24'h77_66_55 + 24'(i)), w);
                end
                idle();
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    #4;
                end
                check("bp_accepted", acc_cnt, 2);
                check("bp_in_ready", in_ready, 0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_total", acc_cnt, 4);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            drive_beat(2'd3, 6'b00_10_01, 24'h33_22_11, 9'h100, w);
        end
        idle();
        wait_drain();
        check("err_sat", err_cnt, 255);

        // Reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(2'd1, 6'b00_10_01, 24'h33_22_11, 9'h033, w);
        drive_beat(2'd3, 6'b00_10_01, 24'h33_22_11, 9'h100, w);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_y_err", y_err, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        drive_beat(2'd0, 6'b00_10_01, 24'h33_22_11, 9'h022, w);
        idle();
        wait_drain();
        check("post_rst_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_cascade_pipe.md
# mux_cascade_pipe

Pipelined, parametrised two-level cascaded multiplexer. A first level picks one of `N_CTRL` candidate select codes using `sel`, and that chosen code then selects one of `N_DATA` data words. Both levels are registered behind a valid/ready handshake with full back-pressure. It replaces the combinational cascaded mux in timing-critical datapaths and adds range checking plus a saturating error count.

## Interface
Parameters:
- `WIDTH`, 8: data word width, ≥1.
- `N_DATA`, 4: data channels, ≥2; need not be a power of two.
- `N_CTRL`, 2: candidate select codes, ≥2.
- `DSEL_W`, derived: `$clog2(N_DATA)`.
- `CSEL_W`, derived: `$clog2(N_CTRL)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an input beat is offered.
- `in_ready`  out  1  the block accepts the beat this cycle.
- `sel`  in  CSEL_W  picks one entry of `ctrl_codes`.
- `ctrl_codes`  in  N_CTRL*DSEL_W  packed select codes; entry k is at [k*DSEL_W +: DSEL_W].
- `data_in`  in  N_DATA*WIDTH  packed data words; word j is at [j*WIDTH +: WIDTH].
- `out_valid`  out  1  `y` is valid.
- `out_ready`  in  1  the downstream consumer accepts `y`.
- `y`  out  WIDTH  the selected word.
- `y_err`  out  1  the code used for this beat was out of range; `y` is 0.
- `err_cnt`  out  8  saturating count of beats that completed with an error.

## Operation
- Stage 1 (S1) registers:
  - `s1_code = ctrl_codes[sel]`, with code 0 when `sel ≥ N_CTRL`;
  - `s1_selerr = (sel ≥ N_CTRL)`;
  - the whole `data_in` vector;
  - `s1_v`.
- Stage 2 (S2) registers:
  - `y = data[s1_code]` when `s1_code < N_DATA` and `!s1_selerr`, otherwise 0;
  - `y_err = s1_selerr | (s1_code ≥ N_DATA)`;
  - `out_valid`.
- Advance rules, with no combinational path from `in_valid` to `in_ready`:
  - `s2_en = !out_valid | out_ready`.
  - `s1_en = !s1_v | s2_en`.
  - `in_ready = s1_en`.
- On each edge with `s2_en`: S2 loads from S1 and `out_valid <= s1_v`.
- On each edge with `s1_en`: S1 loads the inputs and `s1_v <= in_valid`.
- `err_cnt` increments by 1 on every edge where `out_valid & out_ready & y_err`, and saturates at 255.
- `sel`, `ctrl_codes` and `data_in` are sampled only on an accepted beat. Changing them while a beat is in flight has no effect on that beat.
- Out-of-range handling applies only when N_DATA or N_CTRL is not a power of two; otherwise `y_err` is constant 0.

## Timing
- Reset, asynchronous while `rst_n` = 0:
  - `s1_v`, `out_valid`, `y`, `y_err`, `err_cnt` are 0.
  - S1 payload registers are 0.
  - `in_ready` reads 1 once reset releases and `out_valid` is 0.
- Latency: a beat accepted at edge t appears with `out_valid` = 1 after edge t+1, provided the output was not stalled.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- Stall: with `out_ready` = 0 and both stages full, `in_ready` = 0. `y` and `y_err` hold stable while `out_valid & !out_ready`.
- Release after stall: S2 drains and S1 refills on the same edge. No beat is lost or duplicated.
- A bubble in S2 (`out_valid` = 0) never blocks S1.
- Asserting reset mid-stream discards all in-flight beats. There is no partial output.

## Structure
- Shared package `mux_pkg` holds:
  - `function automatic int clog2_min1(int n)`, which returns at least 1;
  - `localparam ERR_CNT_W = 8`.
- Sub-module `mux_nto1_range` (parameters `WIDTH`, `N`) is combinational only. It takes a packed vector and an index and returns the word plus an `oor` flag.
  - It is instantiated twice: for the code select (`WIDTH = DSEL_W`, `N = N_CTRL`) and for the data select.
- Top level contains only the two stage register banks, the handshake logic and `err_cnt`.

## Test plan
- Single beat, defaults (`WIDTH`=8, `N_DATA`=4, `N_CTRL`=2), `data_in` = {0x44,0x33,0x22,0x11} (word 3 to word 0), `ctrl_codes` = {2,1}, `sel`=1, `out_ready`=1 → `y`=0x33, `y_err`=0, two cycles after acceptance.
- Streaming: 16 back-to-back beats with `sel` alternating 0/1 and `out_ready`=1 → 16 outputs on consecutive cycles, in order, against the reference model.
- Back-pressure: 4 beats issued, `out_ready`=0 for 5 cycles → `in_ready` falls after 2 beats are accepted. `y` stays constant. After release, all 4 beats emerge in order with none dropped.
- Range error, `N_DATA`=3: `ctrl_codes` entry 0 = 3, `sel`=0 → `y`=0, `y_err`=1, `err_cnt` goes 0→1.
- Saturation: 300 error beats → `err_cnt`=255.
- Reset while both stages are full → `out_valid`=0 and `err_cnt`=0 immediately. The first beat after reset is output correctly.
